mem_bus_bridge: RTL and testbench
=================================

// Module: mem_bus_bridge
// PURPOSE
//  Sits between the multicycle CPU datapath memory port and an external
//  variable-latency word memory. Latches one CPU read/write request, drives a
//  req/ack handshake to memory, stalls the CPU controller until completion,
//  and returns read data. Flags misaligned, conflicting and timed-out accesses.
// PARAMETERS
//  WIDTH    32  data and CPU address width
//  TIMEOUT  15  max cycles mem_req stays high without mem_ack before abort (>=1)
// PORTS
//  clk        in   1      system clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  cpu_rd     in   1      CPU read request (MemRd)
//  cpu_wr     in   1      CPU write request (MemWr)
//  cpu_addr   in   WIDTH  byte address from the IorD mux
//  cpu_wdata  in   WIDTH  write data (B register)
//  cpu_rdata  out  WIDTH  read data to IR/MDR; holds the last completed read
//  cpu_stall  out  1      1 = CPU controller must hold its current state
//  cpu_err    out  1      one-cycle pulse: access rejected or aborted
//  mem_req    out  1      memory request, held until mem_ack or timeout
//  mem_we     out  1      1 = write, 0 = read; valid while mem_req
//  mem_addr   out  WIDTH-2 word address (cpu_addr[WIDTH-1:2]), latched
//  mem_wdata  out  WIDTH  latched write data
//  mem_ack    in   1      memory completion; sampled only while mem_req=1
//  mem_rdata  in   WIDTH  read data, valid in the mem_ack cycle
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; cpu_rdata=0, cpu_stall=0, cpu_err=0,
//   mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, timeout counter=0. Outputs
//   take reset values immediately, without waiting for a clock edge. A
//   transaction interrupted by reset is dropped and never replayed.
//  FSM states: IDLE, REQ, DONE, ERR.
//  IDLE: new request = cpu_rd|cpu_wr.
//   - cpu_rd&cpu_wr, or cpu_addr[1:0]!=0 -> ERR. No mem_req is issued.
//   - aligned single request -> latch addr/wdata/we, clear counter -> REQ.
//   - cpu_stall is combinational in IDLE: it equals (cpu_rd|cpu_wr) for any
//     request, including bad ones. The CPU therefore holds state on the
//     sampling edge.
//  REQ: mem_req=1, cpu_stall=1. Counter increments each cycle.
//   - mem_ack=1 -> a read registers mem_rdata into cpu_rdata. Go to DONE.
//     Latency from request to DONE is 1 + (cycles until ack).
//   - no ack and counter==TIMEOUT-1 -> drop mem_req, go to ERR.
//   - if mem_ack and timeout occur in the same cycle, ack wins.
//  DONE: one cycle. mem_req=0, cpu_stall=0. cpu_rdata is valid.
//   - cpu_rd/cpu_wr are ignored. The CPU advances on this edge.
//   - next state is always IDLE.
//  ERR: one cycle. cpu_err=1, cpu_stall=0, mem_req=0. Next state is IDLE.
//   - cpu_rdata is unchanged. No write reaches memory.
//  mem_ack seen outside REQ is ignored. cpu_rdata changes only on a read
//   completion or reset. A write completion leaves cpu_rdata unchanged.
//  Back-to-back accesses: the minimum period is 3 cycles
//   (IDLE -> REQ -> DONE) when memory acks in the first REQ cycle.
//  cpu_addr/cpu_wdata may change after IDLE; latched copies drive memory.
// TESTING
//  1 read 0x0000_0008, mem_ack 3 cycles after mem_req rises:
//    -> mem_addr=0x2, mem_we=0, stall high 4 cycles, DONE, cpu_rdata=mem_rdata.
//  2 write 0x0000_0010 data 0xDEAD_BEEF, ack in first REQ cycle:
//    -> mem_we=1, mem_wdata=0xDEADBEEF, stall 2 cycles, cpu_rdata unchanged.
//  3 read 0x0000_0006 (misaligned):
//    -> mem_req never rises, cpu_err pulses 1 cycle, then IDLE.
//  4 cpu_rd and cpu_wr both high at aligned address:
//    -> ERR pulse, no mem_req.
//  5 read, mem_ack never asserted:
//    -> mem_req high exactly 15 cycles, then cpu_err pulse.
//    Also: mem_ack on cycle 15 -> DONE, no error.
//  6 rst_n low while in REQ:
//    -> mem_req=0 and cpu_stall=0 immediately. After release, a fresh read
//       completes normally.

Source files
------------

// File: rtl/mem_bus_bridge.sv
// Bridge between the multicycle CPU memory port and a variable-latency word memory.
// Latches one request, runs a req/ack handshake, stalls the CPU and flags bad or timed-out accesses.
module mem_bus_bridge #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cpu_rd,
    input  logic             cpu_wr,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic [WIDTH-1:0] cpu_rdata,
    output logic             cpu_stall,
    output logic             cpu_err,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-3:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [1:0]       dbg_state_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-3:0] addr_q, addr_d;
    logic             we_q, we_d;

    logic req_any;
    logic bad_req;
    logic timeout_hit;

    assign req_any     = cpu_rd | cpu_wr;
    assign bad_req     = (cpu_rd & cpu_wr) | (cpu_addr[1:0] != 2'b00);
    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

    // Handshake: mem_req rises on entry to REQ and stays high with stable
    // mem_we/mem_addr/mem_wdata until a cycle with mem_ack=1 (transfer done)
    // or the timeout abort; mem_ack is ignored whenever mem_req is low.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        we_d    = we_q;
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    if (bad_req) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_REQ;
                        addr_d  = cpu_addr[WIDTH-1:2];
                        wdata_d = cpu_wdata;
                        we_d    = cpu_wr;
                        cnt_d   = '0;
                    end
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + 1'b1;
                // An ack arriving in the timeout cycle still completes the access.
                if (mem_ack) begin
                    state_d = ST_DONE;
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_ERR;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
        end
    end

    // Stall is gated by rst_n so it reads 0 during reset even with a request pending.
    assign cpu_stall   = rst_n & (((state_q == ST_IDLE) & req_any) | (state_q == ST_REQ));
    assign cpu_err     = (state_q == ST_ERR);
    assign mem_req     = (state_q == ST_REQ);
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign cpu_rdata   = rdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Self-checking bench for mem_bus_bridge: directed table, reset-in-flight sequence,
// and random transactions checked against a transaction-level reference model.
module tb_mem_bus_bridge;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             cpu_rd = 1'b0;
    logic             cpu_wr = 1'b0;
    logic [WIDTH-1:0] cpu_addr = '0;
    logic [WIDTH-1:0] cpu_wdata = '0;
    logic [WIDTH-1:0] cpu_rdata;
    logic             cpu_stall;
    logic             cpu_err;
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-3:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_ack = 1'b0;
    logic [WIDTH-1:0] mem_rdata = '0;
    logic [1:0]       dbg_state;

    mem_bus_bridge #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_rd     (cpu_rd),
        .cpu_wr     (cpu_wr),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .cpu_err    (cpu_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_dly;   // REQ cycles before ack; >= TIMEOUT means never
        logic        exp_err;
        int          exp_stall;
        int          exp_req;
        logic [31:0] exp_rdata;
    } txn_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_rdata;
    txn_t        tbl[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: outcome of one transaction from the access rules alone.
    function automatic txn_t predict(input txn_t t, input logic [31:0] prev);
        logic bad;
        bad = (t.rd && t.wr) || ((t.addr % 4) != 0);
        t.exp_rdata = prev;
        if (bad) begin
            t.exp_err = 1'b1; t.exp_stall = 1; t.exp_req = 0;
        end else if (t.ack_dly < TIMEOUT) begin
            t.exp_err = 1'b0; t.exp_req = t.ack_dly + 1; t.exp_stall = t.exp_req + 1;
            if (t.rd) t.exp_rdata = t.rdata;
        end else begin
            t.exp_err = 1'b1; t.exp_req = TIMEOUT; t.exp_stall = TIMEOUT + 1;
        end
        return t;
    endfunction

    // Drives one transaction starting at a negedge in IDLE; returns at the negedge back in IDLE.
    task automatic run_txn(input txn_t t, output int stall_n, output int req_n, output int err_n,
                           output logic latch_ok, output logic finished);
        stall_n = 0; req_n = 0; err_n = 0; latch_ok = 1'b1; finished = 1'b0;
        cpu_rd = t.rd; cpu_wr = t.wr; cpu_addr = t.addr; cpu_wdata = t.wdata;
        mem_rdata = t.rdata;
        for (int cyc = 0; cyc < 40 && !finished; cyc++) begin
            #1;
            mem_ack = mem_req ? (req_n == t.ack_dly) : 1'($urandom_range(0, 1));
            #1;
            if (cpu_stall) stall_n++;
            if (cpu_err) err_n++;
            if (mem_req) begin
                req_n++;
                if (mem_addr !== t.addr[31:2] || mem_we !== t.wr ||
                    (t.wr && mem_wdata !== t.wdata)) latch_ok = 1'b0;
            end
            if (cyc > 0 && !cpu_stall) finished = 1'b1;
            @(negedge clk);
            if (cyc == 0) begin
                cpu_addr  = $urandom;
                cpu_wdata = $urandom;
            end
        end
        cpu_rd = 1'b0; cpu_wr = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic apply(input txn_t t, input string tag);
        int   stall_n, req_n, err_n;
        logic latch_ok, finished;
        run_txn(t, stall_n, req_n, err_n, latch_ok, finished);
        #1;
        check({tag, "_finished"}, finished, 1'b1);
        check({tag, "_err_pulses"}, err_n, t.exp_err);
        check({tag, "_stall_cycles"}, stall_n, t.exp_stall);
        check({tag, "_req_cycles"}, req_n, t.exp_req);
        check({tag, "_rdata"}, cpu_rdata, t.exp_rdata);
        if (t.exp_req > 0) check({tag, "_latched_req"}, latch_ok, 1'b1);
        last_rdata = t.exp_rdata;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_cpu_stall", cpu_stall, 0);
        check("rst_cpu_err", cpu_err, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        //          rd    wr    addr          wdata         rdata         dly err stall req exp_rdata
        tbl[0] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,        32'h1234_5678, 2,  1'b0, 4,  3,  32'h1234_5678};
        tbl[1] = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'hAAAA_5555, 0,  1'b0, 2,  1,  32'h1234_5678};
        tbl[2] = '{1'b1, 1'b0, 32'h0000_0006, 32'h0,        32'h1111_1111, 0,  1'b1, 1,  0,  32'h1234_5678};
        tbl[3] = '{1'b1, 1'b1, 32'h0000_0020, 32'h0,        32'h1111_1111, 0,  1'b1, 1,  0,  32'h1234_5678};
        tbl[4] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,        32'h2222_2222, 99, 1'b1, 16, 15, 32'h1234_5678};
        tbl[5] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,        32'hCAFE_F00D, 14, 1'b0, 16, 15, 32'hCAFE_F00D};
        tbl[6] = '{1'b0, 1'b1, 32'h0000_0003, 32'h1,        32'h0,         0,  1'b1, 1,  0,  32'hCAFE_F00D};
        tbl[7] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,        32'h0BAD_F00D, 0,  1'b0, 2,  1,  32'h0BAD_F00D};
        tbl[8] = '{1'b0, 1'b1, 32'h0000_0100, 32'h5A5A_5A5A, 32'h3333_3333, 5,  1'b0, 7,  6,  32'h0BAD_F00D};
        for (int i = 0; i < 9; i++) apply(tbl[i], $sformatf("tbl%0d", i));

        // Reset while a read is waiting in REQ.
        cpu_rd = 1'b1; cpu_addr = 32'h0000_0084; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rstreq_pre_mem_req", mem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rstreq_mem_req", mem_req, 1'b0);
        check("rstreq_cpu_stall", cpu_stall, 1'b0);
        check("rstreq_cpu_err", cpu_err, 1'b0);
        check("rstreq_cpu_rdata", cpu_rdata, 0);
        check("rstreq_mem_addr", mem_addr, 0);
        check("rstreq_mem_wdata", mem_wdata, 0);
        cpu_rd = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rstreq_no_replay", mem_req, 1'b0);
        @(negedge clk);
        apply('{1'b1, 1'b0, 32'h0000_0080, 32'h0, 32'h7777_0001, 1, 1'b0, 3, 2, 32'h7777_0001}, "post_rst");

        for (int i = 0; i < 40; i++) begin
            txn_t t;
            int   op;
            op = $urandom_range(0, 5);
            t.addr  = $urandom;
            t.wdata = $urandom;
            t.rdata = $urandom;
            t.ack_dly = $urandom_range(0, TIMEOUT + 2);
            t.rd = (op <= 1) || (op == 4);
            t.wr = (op == 2) || (op == 3) || (op == 4);
            if (op == 5) begin
                t.rd = 1'($urandom_range(0, 1));
                t.wr = !t.rd;
                t.addr[1:0] = 2'($urandom_range(1, 3));
            end else begin
                t.addr[1:0] = 2'b00;
            end
            t = predict(t, last_rdata);
            apply(t, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
